// File: rtl/reg_dump.sv
// reg_dump: walks register addresses 0..NREGS-1 through a combinational read
// port and streams (address, value) beats over a valid/ready handshake.
// Optional build macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
`ifdef REG_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   out_addr_q, out_addr_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DW-1:0]   acc_q, acc_d;
`endif

  // Next-state, index walk and beat capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_FETCH: begin
        out_data_d  = rd_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        acc_d       = acc_q ^ rd_data;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
`ifdef REG_DUMP_CHECKSUM_EN
          else if (idx_q == LAST_IDX) begin
            state_d = S_CSUM;
          end
`endif
          else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_data_d  = acc_q;
        out_addr_d  = '0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        state_d     = S_SEND;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
`ifdef REG_DUMP_CHECKSUM_EN
    busy_d = (state_d == S_FETCH) || (state_d == S_SEND) || (state_d == S_CSUM);
`else
    busy_d = (state_d == S_FETCH) || (state_d == S_SEND);
`endif
  end

  // State and output registers; reset clears any beat in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
